clint_timer: RTL
================

# clint_timer

Multi-hart, memory-mapped machine timer and software-interrupt unit (CLINT layout) on the peripheral bus. It provides one shared 64-bit `mtime` with a programmable prescaler, plus a 64-bit `mtimecmp` and an `msip` bit for each hart. It drives per-hart timer and software interrupt lines into the CPU cores. Bus responses are registered with one-cycle latency.

## Interface

Parameters:

- `NUM_HARTS`, 1: number of harts; each gets its own `mtimecmp`, `msip`, `timer_irq` bit and `soft_irq` bit (1..16).
- `BASE_ADDR`, 32'h0200_0000: base of the 64 KiB register window.
- `PRESC_WIDTH`, 16: width of the prescaler divide register and counter.

Ports:

- `clk`, in, 1: single clock. Everything is in this domain.
- `rst`, in, 1: one clock; reset is synchronous and active-high.
- `req`, in, 1: bus request, sampled every cycle.
- `addr`, in, 32: byte address.
- `wdata`, in, 32: write data.
- `we`, in, 1: 1 = write, 0 = read.
- `rdata`, out, 32: read data, valid while `ready` = 1; otherwise 0.
- `ready`, out, 1: response strobe, exactly one cycle after each accepted `req`.
- `timer_irq`, out, NUM_HARTS: bit h = registered (`mtime` >= `mtimecmp[h]`).
- `soft_irq`, out, NUM_HARTS: bit h = `msip[h]`.

## Operation

Register map (offset = `addr` - `BASE_ADDR`). All accesses are full 32-bit words.

- `0x0000 + 4h`: `msip[h]`. Bit 0 is R/W; bits 31:1 read 0.
- `0x4000 + 8h` / `+8h+4`: `mtimecmp[h]` low / high word, R/W.
- `0xBFF0`: `PRESC`. Bits [PRESC_WIDTH-1:0] are R/W; upper bits read 0.
- `0xBFF8` / `0xBFFC`: `mtime` low / high word, R/W.

Decode rules:

- An address is unmapped if any of the following holds: `addr[1:0]` != 0, the address is outside the window, or the hart index is >= `NUM_HARTS`.
- Unmapped reads return 0. Unmapped writes are ignored. An unmapped access still gets `ready`.

Prescaler and counter:

- Internal counter `pcnt`. In each cycle: if `pcnt` == `PRESC`, then `pcnt` <= 0 and `mtime` <= `mtime` + 1; otherwise `pcnt` <= `pcnt` + 1.
- With `PRESC` = 0, `mtime` increments every cycle.
- `mtime` wraps modulo 2^64: 0xFFFF_FFFF_FFFF_FFFF -> 0. `timer_irq` follows the wrapped value, so it deasserts after the wrap unless `mtimecmp` is also small.
- Writing `PRESC` clears `pcnt` to 0 in the same update.

Write semantics:

- A write to an `mtime` half replaces that half. It takes priority over the increment in that cycle; the other half keeps its pre-write value, with no carry. The write also clears `pcnt` to 0.
- Each `mtimecmp` half is written independently. No hardware locking is applied; software writes the high word to all-ones first to avoid a spurious interrupt.

Read semantics:

- A read returns the register value as it was in the `req` cycle, before that cycle's increment or write.
- No 64-bit snapshot is taken. Software handles hi/lo tearing by rereading.

Interrupts:

- `timer_irq[h]` is recomputed every cycle from the current `mtime` and `mtimecmp[h]`, then registered.
- `soft_irq[h]` is driven directly from the `msip[h]` flop.

Reset (`rst` = 1 at a `clk` edge):

- `mtime` = 0, `pcnt` = 0, `PRESC` = 0.
- Every `mtimecmp` = all-ones, every `msip` = 0.
- `ready` = 0, `rdata` = 0, `timer_irq` = 0, `soft_irq` = 0.
- If a `req` is in flight when `rst` is asserted, it is dropped: no `ready` is issued for it.

## Timing

- Request in cycle N produces `ready` = 1 and valid `rdata` in cycle N+1. Writes are visible to a read issued in cycle N+1 or later.
- `req` may be asserted on consecutive cycles, giving one response per cycle. There is no backpressure and no stall.
- `timer_irq` latency: if `mtime` >= `mtimecmp[h]` holds after the flop update at edge N, then `timer_irq[h]` rises at edge N+1.
  - Example: `mtimecmp` is written to a value <= `mtime` at edge N. The interrupt rises at edge N+1 and falls one edge after a write that makes the compare false.
- `soft_irq[h]` changes at the same edge as the `msip` write, with no additional delay.
- Simultaneous events are ordered: reset > bus write > increment.

## Test plan

1. **Reset values.** Release reset, then read `0xBFF8` in the first idle cycle -> 0. `0x4000` and `0x4004` -> 0xFFFFFFFF. `timer_irq` = 0, `ready` only the cycle after `req`.
2. **Compare and clear.** `NUM_HARTS`=2, `PRESC`=0. Write `mtimecmp[1]` = {0, 100} (high word first). -> `timer_irq[1]` rises one cycle after `mtime` reaches 100; `timer_irq[0]` stays 0. Then write high word 0xFFFFFFFF -> `timer_irq[1]` = 0 two edges after that write's `req`.
3. **Prescaler.** Write `PRESC`=3, then `mtime` low = 0. -> `mtime` increments exactly once per 4 cycles: read at +8 cycles -> 2. Write `PRESC`=0 -> increments every cycle.
4. **Wrap.** Write `mtime` = 0xFFFFFFFF_FFFFFFFE (two writes) and `mtimecmp[0]` = 0xFFFFFFFF_FFFFFFFF. -> `timer_irq[0]` rises, then falls when `mtime` wraps to 0. Subsequent reads show a small value.
5. **Software interrupt and decode.** Write `msip[1]` = 0xFFFFFFFF -> read returns 1 and `soft_irq`=2'b10. Write `0x0000_0008` (hart 2, absent) -> ignored, read returns 0, `ready` still pulses. Misaligned `0xBFF9` reads 0.
6. **Back-to-back and reset mid-operation.** Issue `req` in 3 consecutive cycles -> 3 consecutive `ready` pulses carrying the correct data. Assert `rst` in the cycle after a `req` -> no `ready` for it, and all registers return to reset values.

Source files
------------

// File: rtl/clint_timer.sv
// CLINT-style machine timer and software-interrupt block: shared prescaled 64-bit mtime,
// per-hart mtimecmp/msip, registered bus responses with one-cycle latency.
module clint_timer #(
  parameter int          NUM_HARTS   = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int          PRESC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 we,
  output logic [31:0]          rdata,
  output logic                 ready,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] soft_irq
);

  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic [63:0]            mtime;
  logic [PRESC_WIDTH-1:0] presc;
  logic [PRESC_WIDTH-1:0] pcnt;
  logic [63:0]            mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0]   msip;

  logic [31:0] offset;
  logic [15:0] cmp_off;
  logic        aligned;
  logic        in_window;
  logic        msip_hit;
  logic        cmp_hit;
  logic        presc_hit;
  logic        mtime_lo_hit;
  logic        mtime_hi_hit;
  logic [HW-1:0] msip_idx;
  logic [HW-1:0] cmp_idx;
  logic [31:0] read_val;
  logic        wr;

  // Address decode; hart indices beyond NUM_HARTS fall through as unmapped.
  always_comb begin
    offset       = addr - BASE_ADDR;
    cmp_off      = offset[15:0] - 16'h4000;
    aligned      = (addr[1:0] == 2'b00);
    in_window    = (offset[31:16] == 16'h0000);
    msip_idx     = offset[2 +: HW];
    cmp_idx      = cmp_off[3 +: HW];
    msip_hit     = aligned && in_window && (offset[15:14] == 2'b00) &&
                   ({20'b0, offset[13:2]} < 32'(NUM_HARTS));
    cmp_hit      = aligned && in_window && (offset[15:0] >= 16'h4000) &&
                   (offset[15:0] < 16'hC000) && ({19'b0, cmp_off[15:3]} < 32'(NUM_HARTS));
    presc_hit    = aligned && in_window && (offset[15:0] == 16'hBFF0);
    mtime_lo_hit = aligned && in_window && (offset[15:0] == 16'hBFF8);
    mtime_hi_hit = aligned && in_window && (offset[15:0] == 16'hBFFC);
    wr           = req && we;
  end

  always_comb begin
    read_val = '0;
    if (msip_hit) begin
      read_val = {31'b0, msip[msip_idx]};
    end else if (cmp_hit) begin
      read_val = cmp_off[2] ? mtimecmp[cmp_idx][63:32] : mtimecmp[cmp_idx][31:0];
    end else if (presc_hit) begin
      read_val = 32'(presc);
    end else if (mtime_lo_hit) begin
      read_val = mtime[31:0];
    end else if (mtime_hi_hit) begin
      read_val = mtime[63:32];
    end
  end

  // Later assignments win: bus writes override the prescaler increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime     <= '0;
      presc     <= '0;
      pcnt      <= '0;
      msip      <= '0;
      ready     <= 1'b0;
      rdata     <= '0;
      timer_irq <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      ready <= req;
      rdata <= req ? read_val : 32'h0;

      if (pcnt == presc) begin
        pcnt  <= '0;
        mtime <= mtime + 64'd1;
      end else begin
        pcnt <= pcnt + PRESC_WIDTH'(1);
      end

      if (wr && presc_hit) begin
        presc <= wdata[PRESC_WIDTH-1:0];
        pcnt  <= '0;
      end
      // Half-word writes keep the other half's pre-write value, with no carry between halves.
      if (wr && mtime_lo_hit) begin
        mtime <= {mtime[63:32], wdata};
        pcnt  <= '0;
      end
      if (wr && mtime_hi_hit) begin
        mtime <= {wdata, mtime[31:0]};
        pcnt  <= '0;
      end
      if (wr && msip_hit) msip[msip_idx] <= wdata[0];
      if (wr && cmp_hit) begin
        if (cmp_off[2]) mtimecmp[cmp_idx][63:32] <= wdata;
        else            mtimecmp[cmp_idx][31:0]  <= wdata;
      end

      for (int h = 0; h < NUM_HARTS; h++) timer_irq[h] <= (mtime >= mtimecmp[h]);
    end
  end

  assign soft_irq = msip;

endmodule
